vector_addsub_arbiter: RTL
==========================

Name: vector_addsub_arbiter

Overview:
Shares one vectorAdderSubstractor datapath (LANES x DATA_WIDTH) between two requesters: port 0 is the vector execute stage and port 1 is the reduction/address unit. Each requester issues multi-beat bursts on a valid/ready interface. Burst ownership is granted round-robin and held until the beat marked last. The arbiter drives the combinational adder and registers its result and C/V/N flags into a single output stage tagged with the owner ID.

Parameters:
DATA_WIDTH, 19, bits per lane
LANES, 6, lanes per vector
TAG_WIDTH, 4, requester-supplied tag returned with the result

Ports:
clk  in  1  clock, all state on rising edge
rst_n  in  1  asynchronous active-low reset
req_valid  in  2  per-requester beat valid
req_ready  out  2  per-requester beat accepted
req_last  in  2  beat is final of burst
req_op1  in  2xLANESxDATA_WIDTH  operand1 per requester
req_op2  in  2xLANESxDATA_WIDTH  operand2 per requester
req_mode  in  2  operationMode per requester (0 add, 1 sub)
req_tag  in  2xTAG_WIDTH  tag per requester
alu_op1  out  LANESxDATA_WIDTH  to adder operand1
alu_op2  out  LANESxDATA_WIDTH  to adder operand2
alu_mode  out  1  to adder operationMode
alu_out  in  LANESxDATA_WIDTH  adder result (combinational)
alu_C, alu_V, alu_N  in  LANES each  adder flags
res_valid  out  1  output stage holds a result
res_ready  in  1  consumer accepts result
res_id  out  1  requester that produced result
res_tag  out  TAG_WIDTH  tag of result
res_data  out  LANESxDATA_WIDTH  registered result
res_C, res_V, res_N  out  LANES each  registered flags
busy  out  1  a burst is owned (state != IDLE)

Behaviour:
- Reset (async, rst_n=0): state=IDLE, rr_ptr=0, res_valid=0, res_id=0, res_tag=0, res_data=0, res_C/V/N=0, busy=0. req_ready=0 while in reset.
- FSM states: IDLE, OWN0, OWN1.
- IDLE, one requester valid: grant it. Both valid: grant port rr_ptr. Neither valid: stay in IDLE.
- Grant is combinational in IDLE, so the first beat can be accepted in the same cycle. The FSM moves to OWNx only if the accepted beat has last=0.
- OWNx: only port x may be granted. The other port's req_ready=0 even if its valid is high.
- Accepted beat (valid & ready) with last=1: return to IDLE and set rr_ptr = ~x.
- Single-beat burst (last=1 accepted in IDLE): stay in IDLE and set rr_ptr = ~x.
- req_ready[g] = granted(g) & (!res_valid | res_ready). The output stage is single-entry and accepts a new beat when the held result is consumed in the same cycle.
- alu_op1/op2/mode are muxed from the granted port. With no grant they are driven from port rr_ptr; this does not change any state.
- Latency: a beat accepted in cycle t has res_valid=1 in t+1.
- On acceptance the output stage captures alu_out, C, V, N, tag and id.
- The result is held stable while res_valid & !res_ready.
- res_valid clears on res_ready when no new beat is accepted in that cycle.
- Arithmetic: no widening. Widths, wrap-around and flags come from the adder unchanged.
- Deasserting req_valid mid-burst: ownership is kept. The other requester waits, and no timeout is applied.
- Requester rules: the requester must not change op/mode/tag/last while valid & !ready. Protocol violations are undefined.
- Reset mid-burst: all state clears immediately. The in-flight result is dropped, and that beat is not replayed.

Test Plan:
- Single beat: port0 op1 lane0=5, op2 lane0=3, mode=0, last=1 -> ready same cycle; next cycle res_valid=1, res_id=0, res_data lane0=8, C/V/N lane0=0; rr_ptr=1.
- Subtract negative: port1 lane2 op1=2, op2=7, mode=1 -> res_data lane2=0x7FFFB (19-bit), N[2]=1; tag returned unchanged.
- Contention: both valid, single-beat, held 4 cycles -> grants alternate 0,1,0,1 from reset; res_id sequence 0,1,0,1.
- Burst lock: port0 3-beat burst (last on beat 3) while port1 valid throughout -> port1 ready=0 for 3 acceptances; port1 granted the cycle after port0's last beat.
- Backpressure: res_ready=0 for 3 cycles with port0 valid -> exactly one beat accepted, res_data stable; when res_ready=1, the next beat is accepted in the same cycle and no result is lost or duplicated.
- Reset mid-burst: rst_n=0 during OWN1 with res_valid=1 -> res_valid=0, busy=0 immediately; after release port0 wins first contention (rr_ptr=0).

Source files
------------

// File: rtl/vector_addsub_arbiter.sv
// Round-robin burst arbiter sharing one external lane-wise add/sub datapath
// between two requesters, with a single registered result stage.
module vector_addsub_arbiter #(
  parameter int DATA_WIDTH = 19,
  parameter int LANES      = 6,
  parameter int TAG_WIDTH  = 4
) (
  input  logic                                clk,
  input  logic                                rst_n,
  input  logic [1:0]                          req_valid,
  output logic [1:0]                          req_ready,
  input  logic [1:0]                          req_last,
  input  logic [1:0][LANES*DATA_WIDTH-1:0]    req_op1,
  input  logic [1:0][LANES*DATA_WIDTH-1:0]    req_op2,
  input  logic [1:0]                          req_mode,
  input  logic [1:0][TAG_WIDTH-1:0]           req_tag,
  output logic [LANES*DATA_WIDTH-1:0]         alu_op1,
  output logic [LANES*DATA_WIDTH-1:0]         alu_op2,
  output logic                                alu_mode,
  input  logic [LANES*DATA_WIDTH-1:0]         alu_out,
  input  logic [LANES-1:0]                    alu_C,
  input  logic [LANES-1:0]                    alu_V,
  input  logic [LANES-1:0]                    alu_N,
  output logic                                res_valid,
  input  logic                                res_ready,
  output logic                                res_id,
  output logic [TAG_WIDTH-1:0]                res_tag,
  output logic [LANES*DATA_WIDTH-1:0]         res_data,
  output logic [LANES-1:0]                    res_C,
  output logic [LANES-1:0]                    res_V,
  output logic [LANES-1:0]                    res_N,
  output logic                                busy,
  output logic [1:0]                          dbg_state
);

  // Handshake: a beat on port g transfers on a rising edge where
  // req_valid[g] & req_ready[g]; a result transfers where res_valid & res_ready.

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    OWN0 = 2'd1,
    OWN1 = 2'd2
  } state_t;

  state_t state, state_nx;
  logic   rr_ptr, rr_nx;
  logic   grant_any, grant_id;
  logic   slot_free, accept;

  // Output stage can take a new beat if empty or being drained this cycle.
  assign slot_free = !res_valid || res_ready;

  always_comb begin
    grant_any = 1'b0;
    grant_id  = rr_ptr;
    case (state)
      IDLE: begin
        if (req_valid[0] && req_valid[1]) begin
          grant_any = 1'b1;
          grant_id  = rr_ptr;
        end else if (req_valid[0]) begin
          grant_any = 1'b1;
          grant_id  = 1'b0;
        end else if (req_valid[1]) begin
          grant_any = 1'b1;
          grant_id  = 1'b1;
        end
      end
      OWN0: begin
        grant_any = 1'b1;
        grant_id  = 1'b0;
      end
      OWN1: begin
        grant_any = 1'b1;
        grant_id  = 1'b1;
      end
      default: ;
    endcase
  end

  always_comb begin
    req_ready = 2'b00;
    if (rst_n && grant_any && slot_free) req_ready[grant_id] = 1'b1;
  end

  assign accept = rst_n && grant_any && slot_free && req_valid[grant_id];

  // With no grant the mux still follows rr_ptr; nothing is captured.
  assign alu_op1  = req_op1[grant_id];
  assign alu_op2  = req_op2[grant_id];
  assign alu_mode = req_mode[grant_id];

  always_comb begin
    state_nx = state;
    rr_nx    = rr_ptr;
    if (accept) begin
      if (req_last[grant_id]) begin
        state_nx = IDLE;
        rr_nx    = ~grant_id;
      end else begin
        state_nx = grant_id ? OWN1 : OWN0;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= IDLE;
      rr_ptr <= 1'b0;
    end else begin
      state  <= state_nx;
      rr_ptr <= rr_nx;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      res_valid <= 1'b0;
      res_id    <= 1'b0;
      res_tag   <= '0;
      res_data  <= '0;
      res_C     <= '0;
      res_V     <= '0;
      res_N     <= '0;
    end else if (accept) begin
      res_valid <= 1'b1;
      res_id    <= grant_id;
      res_tag   <= req_tag[grant_id];
      res_data  <= alu_out;
      res_C     <= alu_C;
      res_V     <= alu_V;
      res_N     <= alu_N;
    end else if (res_ready) begin
      res_valid <= 1'b0;
    end
  end

  assign busy      = (state != IDLE);
  assign dbg_state = state;

endmodule
